// File: rtl/pipe_ctrl_seq_pkg.sv
// Shared definitions for the sequential RV32I pipeline control.
// Holds opcode/funct3 constants, the PC_sel and WB_sel encodings, the control
// FSM states and the execute-stage control bundle with its NOP value.
package pipe_ctrl_seq_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FNC_SR     = 3'b101;  // SRL/SRA (and SRLI/SRAI)

  typedef enum logic [2:0] {
    PC_RST   = 3'd0,
    PC_HOLD  = 3'd1,
    PC_PLUS4 = 3'd2,
    PC_ALU   = 3'd3,
    PC_JAL   = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PC4  = 2'd1,
    WB_MEM  = 2'd2,
    WB_ALU  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    RSTH,
    RUN,
    LOAD_WAIT,
    FLUSH
  } state_e;

  typedef struct packed {
    logic       reg_we;
    logic [3:0] alu_sel;
    logic       a_sel;
    logic       b_sel;
    logic       csr_sel;
    logic       csr_we;
    logic [2:0] load_sel;
    wb_sel_e    wb_sel;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       is_load;
    logic [4:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t NOP_BUNDLE = '0;

endpackage

// File: rtl/pipe_ctrl_seq_decode.sv
// ctrl_decode: pure combinational decode of a decode-stage instruction into
// the control bundle, plus source-register usage for hazard detection.
//   instruction_i  decode-stage instruction word
//   inst_valid_i   instruction word is valid
//   bundle_o       decoded control bundle (NOP when invalid or unknown)
//   rs1_used_o/rs2_used_o, rs1_o/rs2_o  source registers read by the instruction
module ctrl_decode
  import pipe_ctrl_seq_pkg::*;
(
  input  logic [31:0]  instruction_i,
  input  logic         inst_valid_i,
  output ctrl_bundle_t bundle_o,
  output logic         rs1_used_o,
  output logic         rs2_used_o,
  output logic [4:0]   rs1_o,
  output logic [4:0]   rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic [4:0] rd;
  logic       unused_imm;

  assign opcode     = instruction_i[6:0];
  assign rd         = instruction_i[11:7];
  assign funct3     = instruction_i[14:12];
  assign rs1_o      = instruction_i[19:15];
  assign rs2_o      = instruction_i[24:20];
  assign bit30      = instruction_i[30];
  assign unused_imm = ^{instruction_i[31], instruction_i[29:25]};

  always_comb begin
    bundle_o   = NOP_BUNDLE;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    if (inst_valid_i) begin
      case (opcode)
        OPC_OP: begin
          bundle_o.reg_we  = 1'b1;
          bundle_o.alu_sel = {bit30, funct3};
          bundle_o.a_sel   = 1'b1;
          bundle_o.b_sel   = 1'b1;
          bundle_o.wb_sel  = WB_ALU;
          bundle_o.rd      = rd;
          rs1_used_o       = 1'b1;
          rs2_used_o       = 1'b1;
        end
        OPC_OPIMM: begin
          // bit30 is immediate data except for the shift-right pair
          bundle_o.reg_we  = 1'b1;
          bundle_o.alu_sel = {(funct3 == FNC_SR) & bit30, funct3};
          bundle_o.a_sel   = 1'b1;
          bundle_o.wb_sel  = WB_ALU;
          bundle_o.rd      = rd;
          rs1_used_o       = 1'b1;
        end
        OPC_LOAD: begin
          bundle_o.reg_we   = 1'b1;
          bundle_o.a_sel    = 1'b1;
          bundle_o.load_sel = funct3;
          bundle_o.wb_sel   = WB_MEM;
          bundle_o.is_load  = 1'b1;
          bundle_o.rd       = rd;
          rs1_used_o        = 1'b1;
        end
        OPC_STORE: begin
          bundle_o.a_sel = 1'b1;
          rs1_used_o     = 1'b1;
          rs2_used_o     = 1'b1;
        end
        OPC_BRANCH: begin
          bundle_o.is_branch = 1'b1;
          rs1_used_o         = 1'b1;
          rs2_used_o         = 1'b1;
        end
        OPC_JAL: begin
          bundle_o.reg_we = 1'b1;
          bundle_o.wb_sel = WB_PC4;
          bundle_o.is_jal = 1'b1;
          bundle_o.rd     = rd;
        end
        OPC_JALR: begin
          bundle_o.reg_we  = 1'b1;
          bundle_o.a_sel   = 1'b1;
          bundle_o.wb_sel  = WB_PC4;
          bundle_o.is_jalr = 1'b1;
          bundle_o.rd      = rd;
          rs1_used_o       = 1'b1;
        end
        OPC_LUI: begin
          bundle_o.reg_we = 1'b1;
          bundle_o.a_sel  = 1'b1;
          bundle_o.wb_sel = WB_ALU;
          bundle_o.rd     = rd;
        end
        OPC_AUIPC: begin
          bundle_o.reg_we = 1'b1;
          bundle_o.wb_sel = WB_ALU;
          bundle_o.rd     = rd;
        end
        OPC_SYSTEM: begin
          // funct3 == 0 (ECALL/EBREAK) carries no CSR access
          if (funct3 != 3'b000) begin
            bundle_o.csr_we  = 1'b1;
            bundle_o.csr_sel = ~funct3[2];
            bundle_o.a_sel   = 1'b1;
            rs1_used_o       = ~funct3[2];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: decodes the decode-stage instruction, registers the control
// bundle into execute, and sequences reset hold, load wait, redirect flush and
// load-use stalls.
//   clk, rst (sync, active-low)
//   instruction, inst_valid   decode-stage instruction
//   should_br, PC             execute-stage branch result and PC
//   Reg_WE..WB_sel            registered execute-stage control
//   PC_sel, stall, flush      fetch/decode steering from the FSM
//   DMEM_sel                  combinational address-region select from PC
module pipe_ctrl_seq
  import pipe_ctrl_seq_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned LOAD_LAT    = 2,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned RST_HOLD    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic            inst_valid,
  input  logic            should_br,
  input  logic [XLEN-1:0] PC,
  output logic            Reg_WE,
  output logic [3:0]      ALU_sel,
  output logic [2:0]      PC_sel,
  output logic            A_sel,
  output logic            B_sel,
  output logic            CSR_sel,
  output logic            CSR_WE,
  output logic [1:0]      DMEM_sel,
  output logic [2:0]      LOAD_sel,
  output logic [1:0]      WB_sel,
  output logic            stall,
  output logic            flush
);

  localparam int unsigned MAX_LF  = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
  localparam int unsigned CNT_MAX = (MAX_LF > RST_HOLD) ? MAX_LF : RST_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_bundle_t     ex_q, ex_d, dec_bundle;
  pc_sel_e          pc_sel;
  logic             stall_c, flush_c;
  logic             rs1_used, rs2_used;
  logic [4:0]       rs1, rs2;
  logic             br_taken, redirect, load_use;
  logic             unused_pc;

  ctrl_decode u_decode (
    .instruction_i (instruction),
    .inst_valid_i  (inst_valid),
    .bundle_o      (dec_bundle),
    .rs1_used_o    (rs1_used),
    .rs2_used_o    (rs2_used),
    .rs1_o         (rs1),
    .rs2_o         (rs2)
  );

  assign br_taken = ex_q.is_branch & should_br;
  assign redirect = ex_q.is_jal | ex_q.is_jalr | br_taken;
  assign load_use = ex_q.is_load && (ex_q.rd != '0) &&
                    ((rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = NOP_BUNDLE;
    pc_sel  = PC_PLUS4;
    stall_c = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      RSTH: begin
        pc_sel = PC_RST;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RUN: begin
        if (ex_q.is_jal)                   pc_sel = PC_JAL;
        else if (ex_q.is_jalr || br_taken) pc_sel = PC_ALU;
        if (ex_q.is_load && (LOAD_LAT > 1)) begin
          state_d = LOAD_WAIT;
          cnt_d   = CNT_W'(LOAD_LAT - 2);
        end else if (redirect && (FLUSH_DEPTH > 0)) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
        end
        // The decode-stage word is wrong-path on a redirect, so it becomes a
        // bubble and any load-use stall it would have raised is dropped.
        if (!redirect) begin
          if (load_use) stall_c = 1'b1;
          else          ex_d    = dec_bundle;
        end
      end
      LOAD_WAIT: begin
        stall_c = 1'b1;
        pc_sel  = PC_HOLD;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RSTH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RSTH;
      cnt_q   <= CNT_W'(RST_HOLD - 1);
      ex_q    <= NOP_BUNDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign Reg_WE   = ex_q.reg_we;
  assign ALU_sel  = ex_q.alu_sel;
  assign A_sel    = ex_q.a_sel;
  assign B_sel    = ex_q.b_sel;
  assign CSR_sel  = ex_q.csr_sel;
  assign CSR_WE   = ex_q.csr_we;
  assign LOAD_sel = ex_q.load_sel;
  assign WB_sel   = ex_q.wb_sel;
  assign PC_sel   = pc_sel;
  assign stall    = stall_c;
  assign flush    = flush_c;

  assign DMEM_sel  = ((PC[31:28] == 4'b0001) || (PC[31:28] == 4'b0011)) ? 2'd1 :
                     (PC[31:28] == 4'b0100) ? 2'd2 : 2'd0;
  assign unused_pc = ^PC;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
module tb_pipe_ctrl_seq;

  logic        clk, rst, inst_valid, should_br;
  logic [31:0] instruction, PC;
  logic        Reg_WE, A_sel, B_sel, CSR_sel, CSR_WE, stall, flush;
  logic [3:0]  ALU_sel;
  logic [2:0]  PC_sel, LOAD_sel;
  logic [1:0]  DMEM_sel, WB_sel;

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [31:0] I_ADD    = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW     = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADDX5  = 32'h00028333; // add  x6,x5,x0
  localparam logic [31:0] I_BEQ    = 32'h00000463; // beq  x0,x0,8
  localparam logic [31:0] I_JAL    = 32'h010000EF; // jal  x1,16

  pipe_ctrl_seq #(
    .XLEN(32), .LOAD_LAT(3), .FLUSH_DEPTH(1), .RST_HOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
    .should_br(should_br), .PC(PC), .Reg_WE(Reg_WE), .ALU_sel(ALU_sel),
    .PC_sel(PC_sel), .A_sel(A_sel), .B_sel(B_sel), .CSR_sel(CSR_sel),
    .CSR_WE(CSR_WE), .DMEM_sel(DMEM_sel), .LOAD_sel(LOAD_sel), .WB_sel(WB_sel),
    .stall(stall), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld);
    instruction = ins;
    inst_valid  = vld;
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    rst = 1'b0; should_br = 1'b0; PC = '0;
    drive(I_ADD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {PC_sel, stall, flush, Reg_WE, CSR_WE};
      n_chk++;
      if (obs !== 7'b0) $display("FAIL reset_active[%0d]: got %b want 0000000", i, obs);
      else n_pass++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      obs = {PC_sel, stall, flush, Reg_WE, CSR_WE};
      n_chk++;
      if (obs !== 7'b0) $display("FAIL reset_hold[%0d]: got %b want 0000000", i, obs);
      else n_pass++;
      tick();
    end
    obs = {PC_sel, stall, flush, Reg_WE, CSR_WE};
    n_chk++;
    if (obs !== {3'd2, 4'b0}) $display("FAIL reset_exit: got %b want 0100000", obs);
    else n_pass++;
  endtask

  task automatic test_add;
    logic [13:0] obs;
    drive(I_ADD, 1'b1);
    tick();
    obs = {Reg_WE, ALU_sel, A_sel, B_sel, WB_sel, PC_sel, stall, flush};
    n_chk++;
    if (obs !== {1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0})
      $display("FAIL add_bundle: got %b want 10000111101000", obs);
    else n_pass++;
    drive(I_ADD, 1'b0);
    tick();
  endtask

  task automatic test_alu_sel;
    logic [31:0] ins [4] = '{32'h40315093, 32'h40010093, 32'h402081B3, 32'h0020D193};
    logic [7:0]  exp [4] = '{8'b1101_1_0_11, 8'b0000_1_0_11, 8'b1000_1_1_11, 8'b0101_1_0_11};
    logic [7:0]  obs;
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 1'b1);
      tick();
      obs = {ALU_sel, A_sel, B_sel, WB_sel};
      n_chk++;
      if (obs !== exp[i]) $display("FAIL alu_sel[%0d]: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
    drive(I_ADD, 1'b0);
    tick();
  endtask

  task automatic test_csr_nop;
    logic [31:0] ins [4] = '{32'h51E09073, 32'h51E0D073, I_ADD, 32'h0000007F};
    logic        vld [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [10:0] exp [4] = '{11'b1_1_0_00_010_000, 11'b1_0_0_00_010_000,
                             11'b0_0_0_00_010_000, 11'b0_0_0_00_010_000};
    logic [10:0] obs;
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], vld[i]);
      tick();
      obs = {CSR_WE, CSR_sel, Reg_WE, WB_sel, PC_sel, LOAD_sel};
      n_chk++;
      if (obs !== exp[i]) $display("FAIL csr_nop[%0d]: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
    drive(I_ADD, 1'b0);
    tick();
  endtask

  task automatic test_load_use;
    logic [8:0] obs;
    logic [4:0] ob2;
    drive(I_LW, 1'b1);
    #1;
    n_chk++;
    if (stall !== 1'b0) $display("FAIL lu_pre: got stall=%b want 0", stall);
    else n_pass++;
    tick();
    drive(I_ADDX5, 1'b1);
    #1;
    obs = {stall, PC_sel, Reg_WE, WB_sel, LOAD_sel[1:0]};
    n_chk++;
    if (obs !== {1'b1, 3'd2, 1'b1, 2'd2, 2'b10}) $display("FAIL lu_hazard: got %b want 101011010", obs);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      ob2 = {stall, PC_sel, Reg_WE};
      n_chk++;
      if (ob2 !== 5'b1_001_0) $display("FAIL lu_wait[%0d]: got %b want 10010", i, ob2);
      else n_pass++;
    end
    tick();
    ob2 = {stall, PC_sel, Reg_WE};
    n_chk++;
    if (ob2 !== 5'b0_010_0) $display("FAIL lu_resume: got %b want 00100", ob2);
    else n_pass++;
    tick();
    ob2 = {Reg_WE, WB_sel, A_sel, B_sel};
    n_chk++;
    if (ob2 !== 5'b1_11_1_1) $display("FAIL lu_add_ex: got %b want 11111", ob2);
    else n_pass++;
    drive(I_ADD, 1'b0);
    tick();
  endtask

  task automatic test_branch;
    logic [5:0] obs;
    logic [5:0] exp [4] = '{6'b011_0_0_0, 6'b010_1_0_0, 6'b010_0_0_0, 6'b010_0_0_1};
    drive(I_BEQ, 1'b1);
    tick();
    should_br = 1'b1;
    drive(I_ADD, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      obs = {PC_sel, flush, stall, Reg_WE};
      n_chk++;
      if (obs !== exp[i]) $display("FAIL br_taken[%0d]: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
    should_br = 1'b0;
    drive(I_BEQ, 1'b1);
    tick();
    drive(I_ADD, 1'b1);
    #1;
    n_chk++;
    if ({PC_sel, flush} !== 4'b010_0) $display("FAIL br_not_taken: got %b want 0100", {PC_sel, flush});
    else n_pass++;
    tick();
    n_chk++;
    if ({flush, Reg_WE} !== 2'b01) $display("FAIL br_nt_next: got %b want 01", {flush, Reg_WE});
    else n_pass++;
    drive(I_ADD, 1'b0);
    tick();
  endtask

  task automatic test_jal;
    logic [7:0] obs;
    logic [7:0] exp [3] = '{8'b100_1_01_0_0, 8'b010_0_00_0_1, 8'b010_0_00_0_0};
    drive(I_JAL, 1'b1);
    tick();
    drive(I_ADD, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      obs = {PC_sel, Reg_WE, WB_sel, A_sel, flush};
      n_chk++;
      if (obs !== exp[i]) $display("FAIL jal[%0d]: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
    drive(I_ADD, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_wait;
    logic [20:0] obs;
    drive(I_LW, 1'b1);
    tick();
    drive(I_ADD, 1'b0);
    tick();
    tick();
    n_chk++;
    if ({stall, PC_sel} !== 4'b1_001) $display("FAIL rmw_in_wait: got %b want 1001", {stall, PC_sel});
    else n_pass++;
    rst = 1'b0;
    PC  = 32'h4000_0000;
    #1;
    n_chk++;
    if (DMEM_sel !== 2'd2) $display("FAIL rmw_dmem: got %0d want 2", DMEM_sel);
    else n_pass++;
    tick();
    obs = {stall, flush, PC_sel, Reg_WE, ALU_sel, A_sel, B_sel, CSR_sel, CSR_WE, LOAD_sel, WB_sel};
    n_chk++;
    if (obs !== 21'b0) $display("FAIL rmw_abort: got %b want all 0", obs);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_chk++;
    if (PC_sel !== 3'd0) $display("FAIL rmw_hold_reload: got PC_sel=%0d want 0", PC_sel);
    else n_pass++;
    tick();
    n_chk++;
    if ({PC_sel, stall} !== 4'b010_0) $display("FAIL rmw_run: got %b want 0100", {PC_sel, stall});
    else n_pass++;
  endtask

  task automatic test_dmem_sel;
    logic [31:0] pcs [6] = '{32'h1000_0000, 32'h3FFF_FFFC, 32'h2000_0000,
                             32'h4000_0010, 32'h5000_0000, 32'hF000_0000};
    logic [1:0]  exp [6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      PC = pcs[i];
      #1;
      n_chk++;
      if (DMEM_sel !== exp[i]) $display("FAIL dmem_sel[%0d]: got %0d want %0d", i, DMEM_sel, exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_sel();
    test_csr_nop();
    test_load_use();
    test_branch();
    test_jal();
    test_reset_mid_wait();
    test_dmem_sel();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
